// File: rtl/debug_trace_buffer_if.sv
// Bus bundle for debug_trace_buffer.
// Groups the probe/capture-control inputs, the read port and the status outputs.
//   master : debug host / probe source (drives probes, control, read address)
//   slave  : trace buffer (drives rd_data, state, fill_count, trig_pos)
interface debug_trace_buffer_if #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 4,
  parameter int CH_W   = 2
);
  logic [NUM_CH*32-1:0] probe_data;
  logic                 probe_en;
  logic                 arm;
  logic                 disarm;
  logic [CH_W-1:0]      trig_ch;
  logic [31:0]          trig_value;
  logic [PTR_W-1:0]     post_len;
  logic [PTR_W-1:0]     rd_idx;
  logic [CH_W-1:0]      rd_ch;
  logic [31:0]          rd_data;
  logic [1:0]           state;
  logic [PTR_W:0]       fill_count;
  logic [PTR_W-1:0]     trig_pos;

  modport master (
    output probe_data, probe_en, arm, disarm, trig_ch, trig_value, post_len,
           rd_idx, rd_ch,
    input  rd_data, state, fill_count, trig_pos
  );

  modport slave (
    input  probe_data, probe_en, arm, disarm, trig_ch, trig_value, post_len,
           rd_idx, rd_ch,
    output rd_data, state, fill_count, trig_pos
  );
endinterface

// File: rtl/debug_trace_buffer.sv
// Debug trace capture unit.
// Samples NUM_CH 32-bit probe channels into a DEPTH-entry ring on cycles where
// probe_en is high. A value match on channel trig_ch, followed by post_len more
// samples, freezes a window of history that is read back through a registered
// port addressed relative to the oldest valid entry.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of debug_trace_buffer_if (probes, control, read port,
//           status: state 0 IDLE / 1 ARMED / 2 TRIGGERED / 3 DONE,
//           fill_count, trig_pos)
module debug_trace_buffer #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int CH_W   = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  debug_trace_buffer_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMED     = 2'd1;
  localparam logic [1:0] TRIGGERED = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [1:0]           state_q, state_n;
  logic [PTR_W-1:0]     wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0]     post_cnt, post_cnt_n;
  logic [PTR_W-1:0]     trig_abs, trig_abs_n;
  logic [PTR_W-1:0]     trig_pos_q;
  logic [PTR_W-1:0]     oldest, oldest_n, rd_addr;
  logic [PTR_W:0]       fill_q, fill_n;
  logic [31:0]          rd_q, rd_word;
  logic                 we, trig_hit;
  logic [NUM_CH*32-1:0] rd_row;

  logic [NUM_CH*32-1:0] mem [DEPTH];

  // Trigger compare; a trig_ch beyond the last channel never matches.
  always_comb begin
    trig_hit = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (bus.trig_ch == CH_W'(c) && bus.probe_data[32*c +: 32] == bus.trig_value)
        trig_hit = 1'b1;
    end
  end

  // Capture control: disarm > arm > capture.
  always_comb begin
    state_n    = state_q;
    wr_ptr_n   = wr_ptr;
    fill_n     = fill_q;
    post_cnt_n = post_cnt;
    trig_abs_n = trig_abs;
    we         = 1'b0;
    if (bus.disarm) begin
      state_n = IDLE;
    end else if (bus.arm) begin
      state_n    = ARMED;
      wr_ptr_n   = '0;
      fill_n     = '0;
      post_cnt_n = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (bus.probe_en) begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            fill_n   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
            if (trig_hit) begin
              trig_abs_n = wr_ptr;
              if (bus.post_len == '0) begin
                state_n = DONE;
              end else begin
                state_n    = TRIGGERED;
                post_cnt_n = bus.post_len;
              end
            end
          end
        end
        TRIGGERED: begin
          if (bus.probe_en) begin
            we         = 1'b1;
            wr_ptr_n   = wr_ptr + 1'b1;
            fill_n     = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
            post_cnt_n = post_cnt - 1'b1;
            if (post_cnt == PTR_W'(1))
              state_n = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // When full, fill's low bits are zero, so oldest collapses to wr_ptr.
  assign oldest   = wr_ptr - fill_q[PTR_W-1:0];
  assign oldest_n = wr_ptr_n - fill_n[PTR_W-1:0];

  // trig_pos is registered from next-state values so it lines up with fill_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      fill_q     <= '0;
      post_cnt   <= '0;
      trig_abs   <= '0;
      trig_pos_q <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_n;
      wr_ptr     <= wr_ptr_n;
      fill_q     <= fill_n;
      post_cnt   <= post_cnt_n;
      trig_abs   <= trig_abs_n;
      trig_pos_q <= trig_abs_n - oldest_n;
      rd_q       <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_ptr] <= bus.probe_data;
  end

  // Read sees pre-edge RAM contents, so a same-edge write returns old data.
  assign rd_addr = oldest + bus.rd_idx;
  assign rd_row  = mem[rd_addr];

  always_comb begin
    rd_word = '1;
    if ({1'b0, bus.rd_idx} < fill_q) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (bus.rd_ch == CH_W'(c))
          rd_word = rd_row[32*c +: 32];
      end
    end
  end

  assign bus.rd_data    = rd_q;
  assign bus.state      = state_q;
  assign bus.fill_count = fill_q;
  assign bus.trig_pos   = trig_pos_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Testbench for debug_trace_buffer (DEPTH=8, NUM_CH=2).
// The driver pushes the expected post-edge outputs from a sample-history model
// into a queue; a monitor pops and compares them after every clock edge.
module tb_debug_trace_buffer;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int CH_W   = 2;

  typedef struct {
    logic [1:0]       st;
    logic [PTR_W:0]   fill;
    logic [PTR_W-1:0] tp;
    logic [31:0]      rd;
    bit               chk_tp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_trace_buffer_if #(.NUM_CH(NUM_CH), .PTR_W(PTR_W), .CH_W(CH_W)) bus ();

  debug_trace_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .PTR_W(PTR_W), .CH_W(CH_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: history of captured samples since the last arm.
  int          m_state, m_total, m_post, m_trig;
  logic [31:0] w0[$], w1[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_total = 0; m_post = 0; m_trig = 0;
    w0.delete(); w1.delete();
  endtask

  task automatic model_step(output exp_t e);
    logic [31:0] c0, c1;
    int idx;
    c0  = bus.probe_data[31:0];
    c1  = bus.probe_data[63:32];
    idx = int'(bus.rd_idx);
    if (idx >= w0.size() || int'(bus.rd_ch) >= NUM_CH) e.rd = '1;
    else e.rd = (bus.rd_ch == 0) ? w0[idx] : w1[idx];
    if (bus.disarm) begin
      m_state = 0;
    end else if (bus.arm) begin
      m_state = 1; m_total = 0;
      w0.delete(); w1.delete();
    end else if (bus.probe_en && (m_state == 1 || m_state == 2)) begin
      if (m_state == 1) begin
        if (int'(bus.trig_ch) < NUM_CH && ((bus.trig_ch == 0) ? c0 : c1) == bus.trig_value) begin
          m_trig = m_total;
          if (bus.post_len == 0) m_state = 3;
          else begin m_state = 2; m_post = int'(bus.post_len); end
        end
      end else begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
      w0.push_back(c0); w1.push_back(c1);
      if (w0.size() > DEPTH) begin
        void'(w0.pop_front()); void'(w1.pop_front());
      end
      m_total++;
    end
    e.st     = 2'(m_state);
    e.fill   = (PTR_W+1)'(w0.size());
    e.tp     = PTR_W'((((m_trig - (m_total - w0.size())) % DEPTH) + DEPTH) % DEPTH);
    e.chk_tp = (m_state == 3);
  endtask

  // Driver acts at posedge+4; one expected entry per edge.
  task automatic cycle();
    exp_t e;
    model_step(e);
    sbq.push_back(e);
    @(posedge clk);
    #4;
  endtask

  task automatic set_probe(int k);
    logic [31:0] v;
    v = 32'h100 + 32'(4 * k);
    bus.probe_data = {~v, v};
  endtask

  task automatic arm_pulse();
    bus.arm = 1'b1; bus.probe_en = 1'b0;
    cycle();
    bus.arm = 1'b0;
  endtask

  task automatic run(int first_k, int n);
    for (int i = 0; i < n; i++) begin
      set_probe(first_k + i);
      bus.probe_en = 1'b1;
      cycle();
    end
    bus.probe_en = 1'b0;
  endtask

  task automatic read(int idx, int ch, logic [31:0] exp, string name);
    bus.probe_en = 1'b0;
    bus.rd_idx = PTR_W'(idx);
    bus.rd_ch  = CH_W'(ch);
    cycle();
    check(name, bus.rd_data, exp);
  endtask

  initial begin : monitor
    exp_t me;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        me = sbq.pop_front();
        check("state", 32'(bus.state), 32'(me.st));
        check("fill_count", 32'(bus.fill_count), 32'(me.fill));
        check("rd_data", bus.rd_data, me.rd);
        if (me.chk_tp) check("trig_pos", 32'(bus.trig_pos), 32'(me.tp));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    bus.probe_data = '0; bus.probe_en = 1'b0; bus.arm = 1'b0; bus.disarm = 1'b0;
    bus.trig_ch = '0; bus.trig_value = '0; bus.post_len = '0;
    bus.rd_idx = '0; bus.rd_ch = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #4;
    check("reset_state", 32'(bus.state), 0);
    check("reset_fill", 32'(bus.fill_count), 0);
    check("reset_rd", bus.rd_data, 0);
    check("reset_tpos", 32'(bus.trig_pos), 0);
    rst_n = 1'b1;

    // 1: basic trigger, post_len=2
    bus.trig_ch = 0; bus.trig_value = 32'h110; bus.post_len = 3'd2;
    arm_pulse();
    run(0, 5);
    check("t1_triggered", 32'(bus.state), 2);
    run(5, 2);
    check("t1_done", 32'(bus.state), 3);
    check("t1_fill", 32'(bus.fill_count), 7);
    check("t1_tpos", 32'(bus.trig_pos), 4);
    read(0, 0, 32'h100, "t1_rd0");
    read(6, 1, ~32'h118, "t1_rd6");

    // 2: wrap
    bus.trig_value = 32'h150; bus.post_len = 3'd3;
    arm_pulse();
    run(0, 24);
    check("t2_done", 32'(bus.state), 3);
    check("t2_fill", 32'(bus.fill_count), 8);
    check("t2_tpos", 32'(bus.trig_pos), 4);
    read(0, 0, 32'h140, "t2_rd0");
    read(7, 0, 32'h15C, "t2_rd7");

    // 3: stall in TRIGGERED
    bus.trig_value = 32'h110; bus.post_len = 3'd3;
    arm_pulse();
    run(0, 6);
    repeat (5) cycle();
    check("t3_stall_state", 32'(bus.state), 2);
    check("t3_stall_fill", 32'(bus.fill_count), 6);
    run(6, 1);
    check("t3_not_done", 32'(bus.state), 2);
    run(7, 1);
    check("t3_done", 32'(bus.state), 3);
    check("t3_tpos", 32'(bus.trig_pos), 4);

    // 4: arm+disarm together, out-of-range reads, trig_ch beyond channels
    bus.trig_value = 32'hFFFF; bus.post_len = 3'd1;
    arm_pulse();
    run(0, 3);
    bus.arm = 1'b1; bus.disarm = 1'b1;
    cycle();
    bus.arm = 1'b0; bus.disarm = 1'b0;
    check("t4_idle", 32'(bus.state), 0);
    check("t4_fill", 32'(bus.fill_count), 3);
    read(1, 0, 32'h104, "t4_rd_kept");
    read(5, 0, 32'hFFFF_FFFF, "t4_rd_idx_oob");
    read(0, 3, 32'hFFFF_FFFF, "t4_rd_ch_oob");
    bus.trig_ch = 2'd3; bus.trig_value = ~32'h104;
    arm_pulse();
    run(0, 10);
    check("t4_no_trig", 32'(bus.state), 1);

    // 5: async reset mid-TRIGGERED
    bus.trig_ch = 0; bus.trig_value = 32'h110; bus.post_len = 3'd5;
    arm_pulse();
    run(0, 6);
    check("t5_triggered", 32'(bus.state), 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_state", 32'(bus.state), 0);
    check("t5_rst_fill", 32'(bus.fill_count), 0);
    check("t5_rst_rd", bus.rd_data, 0);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    model_reset();
    bus.trig_value = 32'h108; bus.post_len = 3'd1;
    arm_pulse();
    run(0, 4);
    check("t5_resume_done", 32'(bus.state), 3);

    // 6: post_len=0, trigger on first sample
    bus.trig_value = 32'h100; bus.post_len = 3'd0;
    arm_pulse();
    run(0, 1);
    check("t6_done", 32'(bus.state), 3);
    check("t6_fill", 32'(bus.fill_count), 1);
    check("t6_tpos", 32'(bus.trig_pos), 0);
    run(1, 2);
    check("t6_frozen", 32'(bus.fill_count), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.probe_data = {32'($urandom_range(0, 7)), 32'($urandom_range(0, 7))};
      bus.probe_en   = ($urandom_range(0, 3) != 0);
      bus.arm        = ($urandom_range(0, 19) == 0);
      bus.disarm     = ($urandom_range(0, 49) == 0);
      bus.trig_ch    = CH_W'($urandom_range(0, 3));
      bus.trig_value = 32'($urandom_range(0, 7));
      bus.post_len   = PTR_W'($urandom_range(0, 7));
      bus.rd_idx     = PTR_W'($urandom_range(0, 7));
      bus.rd_ch      = CH_W'($urandom_range(0, 3));
      cycle();
    end
    bus.probe_en = 1'b0; bus.arm = 1'b0; bus.disarm = 1'b0;

    repeat (3) @(posedge clk);
    #4;
    check("scoreboard_drained", 32'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
